// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word pipeline requests into word-aligned
// data-memory accesses. Sub-word stores are done as read-modify-write because
// the memory only writes whole words. Loads are lane-extracted little-endian
// and sign- or zero-extended. Exactly one response is returned per request.
module load_store_unit #(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [1:0]  ReqSize,
    input  logic        ReqUnsigned,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        MisalignErr,
    output logic        MemReadValid,
    output logic [31:0] MemReadAddr,
    input  logic [31:0] MemReadData,
    input  logic        MemReadReady,
    output logic        MemWriteValid,
    output logic [31:0] MemWriteAddr,
    output logic [31:0] MemWriteData
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] merged_q;
    logic [31:0] resp_data_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        err_q;

    logic        req_misaligned;
    logic [31:0] req_addr_eff;
    logic [31:0] aligned_addr;
    logic        in_read;

    // Pull the addressed byte/half out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   extract_lane = {{24{~is_unsigned & b[7]}}, b};
            2'b01:   extract_lane = {{16{~is_unsigned & h[15]}}, h};
            default: extract_lane = word;
        endcase
    endfunction

    // Replace only the addressed lane of the read word with the store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic [31:0] wdata);
        logic [31:0] result;
        result = word;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    result[7:0]   = wdata[7:0];
                    2'd1:    result[15:8]  = wdata[7:0];
                    2'd2:    result[23:16] = wdata[7:0];
                    default: result[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1])
                    result[31:16] = wdata[15:0];
                else
                    result[15:0] = wdata[15:0];
            end
            default: result = wdata;
        endcase
        merge_lane = result;
    endfunction

    // Classify the incoming request and, with checking disabled, force its address aligned.
    always_comb begin
        req_misaligned = 1'b0;
        req_addr_eff   = ReqAddr;
        if (CHECK_ALIGN) begin
            case (ReqSize)
                2'b01:   req_misaligned = ReqAddr[0];
                2'b10:   req_misaligned = (ReqAddr[1:0] != 2'b00);
                2'b11:   req_misaligned = 1'b1;
                default: req_misaligned = 1'b0;
            endcase
        end else begin
            case (ReqSize)
                2'b00:   req_addr_eff = ReqAddr;
                2'b01:   req_addr_eff = {ReqAddr[31:1], 1'b0};
                default: req_addr_eff = {ReqAddr[31:2], 2'b00};
            endcase
        end
    end

    // Main control FSM: accept, read (with stall), merge/write, then respond.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            addr_q      <= '0;
            merged_q    <= '0;
            resp_data_q <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid) begin
                        addr_q      <= req_addr_eff;
                        size_q      <= ReqSize;
                        unsigned_q  <= ReqUnsigned;
                        merged_q    <= ReqWData;
                        resp_data_q <= '0;
                        if (req_misaligned) begin
                            err_q <= 1'b1;
                            state <= RESP;
                        end else if (!ReqWrite) begin
                            state <= LOAD;
                        end else if (ReqSize[1]) begin
                            state <= RMW_WR;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    if (MemReadReady) begin
                        resp_data_q <= extract_lane(MemReadData, addr_q[1:0], size_q, unsigned_q);
                        state       <= RESP;
                    end
                end
                RMW_RD: begin
                    if (MemReadReady) begin
                        merged_q <= merge_lane(MemReadData, addr_q[1:0], size_q, merged_q);
                        state    <= RMW_WR;
                    end
                end
                RMW_WR: begin
                    state <= RESP;
                end
                RESP: begin
                    resp_data_q <= '0;
                    err_q       <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Decode state into the handshake and memory-port outputs; addresses read as 0 when idle.
    always_comb begin
        in_read       = (state == LOAD) || (state == RMW_RD);
        aligned_addr  = {addr_q[31:2], 2'b00};
        ReqReady      = (state == IDLE);
        RespValid     = (state == RESP);
        RespData      = resp_data_q;
        MisalignErr   = err_q;
        MemReadValid  = in_read;
        MemReadAddr   = in_read ? aligned_addr : '0;
        MemWriteValid = (state == RMW_WR);
        MemWriteAddr  = (state == RMW_WR) ? aligned_addr : '0;
        MemWriteData  = (state == RMW_WR) ? merged_q : '0;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage that sits directly upstream of the data memory and drives its read and write ports.
- Converts pipeline load/store requests of byte, halfword or word size into word-aligned memory accesses.
- Sub-word stores use read-modify-write, because the data memory writes whole words only.
- Performs little-endian lane extraction, sign/zero extension and alignment checking, and returns one response per request.

Parameters:
- CHECK_ALIGN, 1, when 1 misaligned or illegal-size requests raise MisalignErr and perform no memory access; when 0 low address bits are ignored (forced aligned).

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  unit can accept a request
- ReqWrite  input  1  1 = store, 0 = load
- ReqAddr  input  32  byte address
- ReqWData  input  32  store data, right-aligned
- ReqSize  input  2  00 byte, 01 half, 10 word, 11 illegal
- ReqUnsigned  input  1  1 = zero-extend loads, 0 = sign-extend
- RespValid  output  1  one-cycle completion pulse
- RespData  output  32  load result (0 for stores/errors)
- MisalignErr  output  1  qualifies RespValid: request rejected
- MemReadValid  output  1  to data memory ReadValid
- MemReadAddr  output  32  word-aligned read address
- MemReadData  input  32  from data memory ReadData (combinational)
- MemReadReady  input  1  from data memory ReadReady
- MemWriteValid  output  1  to data memory WriteValid
- MemWriteAddr  output  32  word-aligned write address
- MemWriteData  output  32  full merged word

Behaviour:
- Reset value of every output and register: RespValid 0, RespData 0, MisalignErr 0, all Mem* outputs 0, state IDLE. ReqReady is 1 as soon as RESET deasserts.
- FSM states: IDLE, LOAD, RMW_RD, RMW_WR, RESP.
- ReqReady = (state==IDLE). A request is accepted on a rising edge with ReqValid&ReqReady, and addr/wdata/size/unsigned/write are latched then.
- Transitions from IDLE on accept:
  - Error (misaligned or illegal size) -> RESP.
  - Load -> LOAD.
  - Word store -> RMW_WR.
  - Byte/half store -> RMW_RD.
- Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size 11. This check applies only when CHECK_ALIGN=1.
- LOAD / RMW_RD:
  - MemReadValid=1 and MemReadAddr={addr[31:2],2'b00}; these are combinational from state and latched regs.
  - The unit holds in the state while MemReadReady=0, with address stable.
  - On an edge with MemReadReady=1, LOAD captures the extracted data into RespData and goes to RESP. RMW_RD captures the merged word and goes to RMW_WR.
- Lane rules (little-endian):
  - Byte k sits at bits [8k+7:8k], k=addr[1:0].
  - Half sits at [16h+15:16h], h=addr[1].
  - Sign extension takes the top bit of the extracted lane unless ReqUnsigned=1.
- Merge rule: only the addressed lane is replaced with ReqWData[7:0] or [15:0]; the other bytes keep the read value.
- RMW_WR:
  - MemWriteValid=1 for exactly one cycle, with MemWriteAddr aligned and MemWriteData equal to the merged word (ReqWData for word stores).
  - Next state is RESP. The memory commits on the edge leaving RMW_WR.
- RESP:
  - RespValid=1 for exactly one cycle, then the FSM returns to IDLE.
  - RespData is the load result, or 0 for stores and errors.
  - MisalignErr=1 only for errors.
- Latency with MemReadReady constant 1, request accepted at edge N:
  - Load: RespValid during cycle N+2.
  - Word store: write in cycle N+1, RespValid in cycle N+2.
  - Sub-word store: write in cycle N+2, RespValid in cycle N+3.
  - Error: RespValid in cycle N+1.
- Throughput: no new request is accepted while not IDLE. The next request can be accepted on the edge leaving RESP+IDLE, i.e. the minimum spacing equals latency+1.
- MemReadValid and MemWriteValid are never high in the same cycle.
- Reset mid-operation returns to IDLE immediately and clears all outputs. A sub-word store aborted before RMW_WR leaves memory unchanged, and no response is issued for an aborted request.

Test Plan:
- Word store 0xDEADBEEF to 0x00000C00, then word load from 0xC00 -> MemWriteValid one pulse with data 0xDEADBEEF; load RespData=0xDEADBEEF two cycles after accept.
- Signed byte load at 0xC03 with memory word 0x80123456 -> RespData=0xFFFFFF80; the same with ReqUnsigned=1 -> 0x00000080.
- Half store 0xABCD to 0xC02 over word 0x11223344 -> one read then one write of 0xABCD3344 to 0xC00; RespValid in cycle N+3.
- Word load at 0xC01 and half at 0xC03, CHECK_ALIGN=1 -> RespValid+MisalignErr at N+1, RespData=0, no MemReadValid/MemWriteValid.
- MemReadReady held 0 for 3 cycles during a load -> MemReadValid and address stable, ReqReady 0, RespValid only after Ready rises.
- RESET asserted during RMW_RD of a byte store -> outputs 0 asynchronously, no write pulse, memory word unchanged, ReqReady 1 after release.
